// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl: sequences pulse/clear strobes to the seconds, minutes and hours counters.
// Optional macro WATCH_AUTO_REPEAT_EN adds hold-to-repeat on btn_inc in the SET modes.
module watch_time_ctrl #(
    parameter int PLS_W      = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_clr,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_pls,
    output logic       min_pls,
    output logic       hr_pls,
    output logic       sec_clr,
    output logic       min_clr,
    output logic       hr_clr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;
    localparam logic [1:0] MODE_SET_SEC = 2'd3;

    localparam logic [1:0] CH_IDLE = 2'd0;
    localparam logic [1:0] CH_HIGH = 2'd1;
    localparam logic [1:0] CH_LOW  = 2'd2;

    localparam int PW_W = $clog2(PLS_W + 1);
    localparam int BD_W = $clog2(BLINK_DIV + 1);
    localparam logic [PW_W-1:0] PLS_LAST   = PW_W'(PLS_W - 1);
    localparam logic [PW_W-1:0] PLS_LOAD   = PW_W'(PLS_W);
    localparam logic [BD_W-1:0] BLINK_LAST = BD_W'(BLINK_DIV - 1);

    // Button vectors are ordered {clr, inc, mode}; channel index 0=sec, 1=min, 2=hr.
    logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [2:0]      evt_q, evt_d;
    logic [1:0]      carry_dly_q, carry_dly_d, carry_fall_q, carry_fall_d;
    logic [1:0]      mode_q, mode_d;
    logic            blink_q, blink_d;
    logic [BD_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]      ch_st_q [3];
    logic [1:0]      ch_st_d [3];
    logic [PW_W-1:0] ch_cnt_q [3];
    logic [PW_W-1:0] ch_cnt_d [3];
    logic [PW_W-1:0] clr_cnt_q [3];
    logic [PW_W-1:0] clr_cnt_d [3];
    logic [2:0]      pend_q, pend_d, clr_wait_q, clr_wait_d;
    logic [2:0]      sel, pls_req, clr_req, pend_eff, clr_start;
    logic            run, inc_req, rep_fire;

    always_comb begin
        sync1_d      = {btn_clr, btn_inc, btn_mode};
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        evt_d        = sync2_q & ~sync3_q;
        carry_dly_d  = {min_carry, sec_carry};
        carry_fall_d = carry_dly_q & ~{min_carry, sec_carry};
    end

    always_comb begin
        run        = (mode_q == MODE_RUN);
        sel        = {mode_q == MODE_SET_HR, mode_q == MODE_SET_MIN, mode_q == MODE_SET_SEC};
        inc_req    = evt_q[1] | rep_fire;
        pls_req[0] = run ? tick_1hz        : (inc_req & sel[0]);
        pls_req[1] = run ? carry_fall_q[0] : (inc_req & sel[1]);
        pls_req[2] = run ? carry_fall_q[1] : (inc_req & sel[2]);
        clr_req    = evt_q[2] ? (run ? 3'b111 : sel) : 3'b000;
    end

`ifdef WATCH_AUTO_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_DLY + 1);
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;

    // After the first repeat the counter is rewound so later repeats come every REPEAT_PER.
    always_comb begin
        rep_fire  = 1'b0;
        rep_cnt_d = '0;
        if (!run && sync2_q[1]) begin
            if (rep_cnt_q == RP_W'(REPEAT_DLY - 1)) begin
                rep_fire  = 1'b1;
                rep_cnt_d = RP_W'(REPEAT_DLY - REPEAT_PER);
            end else begin
                rep_cnt_d = rep_cnt_q + RP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        mode_d      = evt_q[0] ? mode_q + 2'd1 : mode_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (evt_q[0]) begin
            blink_cnt_d = '0;
            blink_d     = (mode_d != MODE_RUN);
        end else if (run) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BD_W'(1);
        end
    end

    // A clear cancels the pending pulse before anything else looks at it.
    always_comb begin
        pend_eff   = '0;
        pend_d     = '0;
        clr_start  = '0;
        clr_wait_d = '0;
        for (int i = 0; i < 3; i++) begin
            ch_st_d[i]  = ch_st_q[i];
            ch_cnt_d[i] = ch_cnt_q[i];
            pend_eff[i] = pend_q[i] & ~clr_req[i];
            pend_d[i]   = pend_eff[i];
            case (ch_st_q[i])
                CH_IDLE: begin
                    if (pls_req[i]) begin
                        ch_st_d[i]  = CH_HIGH;
                        ch_cnt_d[i] = '0;
                    end
                end
                CH_HIGH: begin
                    pend_d[i] = pend_eff[i] | pls_req[i];
                    if (ch_cnt_q[i] == PLS_LAST) begin
                        ch_st_d[i]  = CH_LOW;
                        ch_cnt_d[i] = '0;
                    end else begin
                        ch_cnt_d[i] = ch_cnt_q[i] + PW_W'(1);
                    end
                end
                CH_LOW: begin
                    if (ch_cnt_q[i] == PLS_LAST) begin
                        pend_d[i]   = 1'b0;
                        ch_cnt_d[i] = '0;
                        ch_st_d[i]  = (pend_eff[i] | pls_req[i]) ? CH_HIGH : CH_IDLE;
                    end else begin
                        pend_d[i]   = pend_eff[i] | pls_req[i];
                        ch_cnt_d[i] = ch_cnt_q[i] + PW_W'(1);
                    end
                end
                default: begin
                    ch_st_d[i]  = CH_IDLE;
                    ch_cnt_d[i] = '0;
                    pend_d[i]   = 1'b0;
                end
            endcase
            // A clear waits out any high phase so the counter never sees both at once.
            clr_start[i]  = (clr_req[i] | clr_wait_q[i]) & (ch_st_d[i] != CH_HIGH);
            clr_wait_d[i] = (clr_req[i] | clr_wait_q[i]) & ~clr_start[i];
            if (clr_start[i])               clr_cnt_d[i] = PLS_LOAD;
            else if (clr_cnt_q[i] != '0)    clr_cnt_d[i] = clr_cnt_q[i] - PW_W'(1);
            else                            clr_cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            evt_q        <= '0;
            carry_dly_q  <= '0;
            carry_fall_q <= '0;
            mode_q       <= MODE_RUN;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
            pend_q       <= '0;
            clr_wait_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                ch_st_q[i]   <= CH_IDLE;
                ch_cnt_q[i]  <= '0;
                clr_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            evt_q        <= evt_d;
            carry_dly_q  <= carry_dly_d;
            carry_fall_q <= carry_fall_d;
            mode_q       <= mode_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
            pend_q       <= pend_d;
            clr_wait_q   <= clr_wait_d;
            for (int i = 0; i < 3; i++) begin
                ch_st_q[i]   <= ch_st_d[i];
                ch_cnt_q[i]  <= ch_cnt_d[i];
                clr_cnt_q[i] <= clr_cnt_d[i];
            end
        end
    end

    assign sec_pls = (ch_st_q[0] == CH_HIGH);
    assign min_pls = (ch_st_q[1] == CH_HIGH);
    assign hr_pls  = (ch_st_q[2] == CH_HIGH);
    assign sec_clr = (clr_cnt_q[0] != '0);
    assign min_clr = (clr_cnt_q[1] != '0);
    assign hr_clr  = (clr_cnt_q[2] != '0);
    assign mode    = mode_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Bench for watch_time_ctrl: directed steps plus random traffic checked every cycle against
// a timestamp-based model (pulse start times, free times, pending flags, mode-entry time).
module tb_watch_time_ctrl;

    localparam int PW = 4;
    localparam int BD = 16;
    localparam int RD = 40;
    localparam int RP = 10;
`ifdef WATCH_AUTO_REPEAT_EN
    localparam int EXP_REP = 5;
`else
    localparam int EXP_REP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0;
    logic sec_carry = 1'b0, min_carry = 1'b0;
    logic sec_pls, min_pls, hr_pls, sec_clr, min_clr, hr_clr, blink;
    logic [1:0] mode;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    watch_time_ctrl #(.PLS_W(PW), .BLINK_DIV(BD), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_clr(btn_clr), .sec_carry(sec_carry), .min_carry(min_carry),
        .sec_pls(sec_pls), .min_pls(min_pls), .hr_pls(hr_pls),
        .sec_clr(sec_clr), .min_clr(min_clr), .hr_clr(hr_clr), .mode(mode), .blink(blink)
    );

    // Model: e counts clock edges since reset release; hist[0] = level sampled one edge ago.
    int e, m_mode, m_mchg;
    int st[3], free_at[3], clr_st[3];
    bit pend[3], cwait[3];
    bit hm[4], hi[4], hc[4];
    bit hsc[2], hmc[2];
`ifdef WATCH_AUTO_REPEAT_EN
    int m_held;
`endif
    int pls_cnt[3], clr_cnt[3], all_clr_cyc;
    logic [2:0] prev_pls, prev_clr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic model_reset();
        e = 0; m_mode = 0; m_mchg = 0;
`ifdef WATCH_AUTO_REPEAT_EN
        m_held = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            st[i] = -1000; free_at[i] = 0; clr_st[i] = -1000; pend[i] = 0; cwait[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin hm[i] = 0; hi[i] = 0; hc[i] = 0; end
        for (int i = 0; i < 2; i++) begin hsc[i] = 0; hmc[i] = 0; end
        prev_pls = '0; prev_clr = '0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin pls_cnt[i] = 0; clr_cnt[i] = 0; end
        all_clr_cyc = 0;
    endtask

    task automatic model_edge();
        bit ev_mode, ev_inc, ev_clr, fall_s, fall_m, fire, hi_now;
        bit req[3], creq[3];
        int tgt;
        e++;
        // A press becomes an event three edges after the first edge that samples it high.
        ev_mode = hm[2] && !hm[3];
        ev_inc  = hi[2] && !hi[3];
        ev_clr  = hc[2] && !hc[3];
        fall_s  = hsc[1] && !hsc[0];
        fall_m  = hmc[1] && !hmc[0];
        fire    = 0;
`ifdef WATCH_AUTO_REPEAT_EN
        if (m_mode != 0 && hi[1]) m_held++; else m_held = 0;
        fire = (m_held >= RD) && ((m_held - RD) % RP == 0);
`endif
        for (int i = 0; i < 3; i++) begin req[i] = 0; creq[i] = 0; end
        if (m_mode == 0) begin
            req[0] = tick_1hz; req[1] = fall_s; req[2] = fall_m;
            for (int i = 0; i < 3; i++) creq[i] = ev_clr;
        end else begin
            tgt = (m_mode == 1) ? 2 : ((m_mode == 2) ? 1 : 0);
            req[tgt]  = ev_inc || fire;
            creq[tgt] = ev_clr;
        end
        for (int i = 0; i < 3; i++) begin
            if (creq[i]) pend[i] = 0;
            if (pend[i] && e >= free_at[i]) begin
                st[i] = e; free_at[i] = e + 2 * PW; pend[i] = 0;
            end else if (req[i]) begin
                if (e >= free_at[i]) begin st[i] = e; free_at[i] = e + 2 * PW; end
                else pend[i] = 1;
            end
            hi_now = (e >= st[i]) && (e < st[i] + PW);
            if ((creq[i] || cwait[i]) && !hi_now) begin clr_st[i] = e; cwait[i] = 0; end
            else cwait[i] = creq[i] || cwait[i];
        end
        if (ev_mode) begin m_mode = (m_mode + 1) % 4; m_mchg = e; end
        for (int i = 3; i > 0; i--) begin hm[i] = hm[i-1]; hi[i] = hi[i-1]; hc[i] = hc[i-1]; end
        hm[0] = btn_mode; hi[0] = btn_inc; hc[0] = btn_clr;
        hsc[1] = hsc[0]; hsc[0] = sec_carry;
        hmc[1] = hmc[0]; hmc[0] = min_carry;
    endtask

    task automatic check_outputs();
        logic [2:0] ep, ec, gp, gc;
        logic eb;
        for (int i = 0; i < 3; i++) begin
            ep[i] = (e >= st[i]) && (e < st[i] + PW);
            ec[i] = (e >= clr_st[i]) && (e < clr_st[i] + PW);
        end
        eb = (m_mode != 0) && ((((e - m_mchg) / BD) % 2) == 0);
        gp = {hr_pls, min_pls, sec_pls};
        gc = {hr_clr, min_clr, sec_clr};
        chk("pulses", gp, ep);
        chk("clears", gc, ec);
        chk("mode", mode, m_mode);
        chk("blink", blink, eb);
        for (int i = 0; i < 3; i++) begin
            if (gp[i] && !prev_pls[i]) pls_cnt[i]++;
            if (gc[i] && !prev_clr[i]) clr_cnt[i]++;
        end
        if (gc == 3'b111) all_clr_cyc++;
        prev_pls = gp;
        prev_clr = gc;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_mode = v;
            1: btn_inc  = v;
            default: btn_clr = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        repeat (hold) cycle();
        set_btn(which, 1'b0);
        repeat (4) cycle();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick_1hz = 0; btn_mode = 0; btn_inc = 0; btn_clr = 0; sec_carry = 0; min_carry = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_counts();
    endtask

    initial begin
        // Reset state and tick latency
        apply_reset();
        chk("reset_outs", {sec_pls, min_pls, hr_pls, sec_clr, min_clr, hr_clr, mode, blink}, 0);
        tick_1hz = 1; cycle(); tick_1hz = 0;
        chk("tick_latency", sec_pls, 1);
        repeat (3) cycle();
        chk("tick_high_4", sec_pls, 1);
        cycle();
        chk("tick_low_after_4", sec_pls, 0);
        repeat (6) cycle();

        // RUN carries and busy/pending/drop
        clear_counts();
        sec_carry = 1; repeat (3) cycle(); sec_carry = 0; repeat (12) cycle();
        chk("sec_carry_min_pls", pls_cnt[1], 1);
        chk("sec_carry_no_hr", pls_cnt[2], 0);
        min_carry = 1; repeat (3) cycle(); min_carry = 0; repeat (12) cycle();
        chk("min_carry_hr_pls", pls_cnt[2], 1);
        clear_counts();
        tick_1hz = 1; cycle(); tick_1hz = 0; cycle();
        tick_1hz = 1; cycle(); tick_1hz = 0; cycle();
        tick_1hz = 1; cycle(); tick_1hz = 0;
        repeat (25) cycle();
        chk("tick_pending_drop", pls_cnt[0], 2);

        // SET_MIN: time halted, inc routed, carries ignored
        press(0, 3); press(0, 3);
        chk("mode_set_min", mode, 2);
        chk("blink_on_entry", blink, 1);
        clear_counts();
        for (int k = 0; k < 40; k++) begin tick_1hz = (k % 5 == 0); cycle(); end
        tick_1hz = 0;
        chk("set_ticks_ignored", pls_cnt[0], 0);
        press(1, 3); repeat (10) cycle();
        chk("set_inc_min", pls_cnt[1], 1);
        sec_carry = 1; repeat (3) cycle(); sec_carry = 0; repeat (12) cycle();
        chk("set_carry_ignored", pls_cnt[1], 1);

        // Clears: selected field in SET_SEC, all three in RUN
        press(0, 3);
        chk("mode_set_sec", mode, 3);
        clear_counts();
        press(2, 3); repeat (8) cycle();
        chk("set_sec_clr", clr_cnt[0], 1);
        chk("set_min_clr_quiet", clr_cnt[1], 0);
        chk("set_hr_clr_quiet", clr_cnt[2], 0);
        press(0, 3);
        clear_counts();
        press(2, 3); repeat (8) cycle();
        chk("run_clr_all_together", all_clr_cyc, PW);

        // Random traffic over all inputs
        for (int k = 0; k < 900; k++) begin
            tick_1hz = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0)  sec_carry = ~sec_carry;
            if ($urandom_range(0, 9) == 0)  min_carry = ~min_carry;
            if ($urandom_range(0, 39) == 0) btn_mode  = ~btn_mode;
            if ($urandom_range(0, 7) == 0)  btn_inc   = ~btn_inc;
            if ($urandom_range(0, 29) == 0) btn_clr   = ~btn_clr;
            cycle();
        end
        tick_1hz = 0;

        // Asynchronous reset in the middle of a pulse with a request pending
        apply_reset();
        tick_1hz = 1; cycle(); tick_1hz = 0; cycle();
        tick_1hz = 1; cycle(); tick_1hz = 0; cycle();
        chk("pre_rst_pulse_high", sec_pls, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {sec_pls, min_pls, hr_pls, sec_clr, min_clr, hr_clr, mode, blink}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_counts();
        repeat (20) cycle();
        chk("no_residual_pulse", pls_cnt[0], 0);
        chk("mode_run_after_rst", mode, 0);

        // Holding btn_inc in SET_HR
        press(0, 3);
        chk("mode_set_hr", mode, 1);
        clear_counts();
        btn_inc = 1; repeat (75) cycle(); btn_inc = 0;
        repeat (20) cycle();
        chk("hold_inc_hr_count", pls_cnt[2], EXP_REP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_time_ctrl.md
Name: watch_time_ctrl

Overview:
Sequencing controller for the watch's three pulse counters (seconds mod-60, minutes mod-60, hours). Drives each counter's pulse input and clear input.
- RUN mode: chains 1 Hz ticks and the counter carries.
- SET modes: routes user button presses to one selected field.
- Provides the mode and blink indication to the display block.

Parameters:
PLS_W, 4, high-cycles and minimum low-cycles of every generated pulse/clear strobe (>=3)
BLINK_DIV, 25000000, clk cycles per blink half-period
REPEAT_DLY, 50000000, hold time before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_PER, 10000000, auto-repeat interval (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick_1hz  in  1  single-cycle strobe, 1 per second
btn_mode  in  1  raw button level, asynchronous
btn_inc  in  1  raw button level, asynchronous
btn_clr  in  1  raw button level, asynchronous
sec_carry  in  1  seconds counter plso
min_carry  in  1  minutes counter plso
sec_pls  out  1  pulse to seconds counter
min_pls  out  1  pulse to minutes counter
hr_pls  out  1  pulse to hours counter
sec_clr  out  1  clear to seconds counter
min_clr  out  1  clear to minutes counter
hr_clr  out  1  clear to hours counter
mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC
blink  out  1  field-blink enable for display

Behaviour:
Reset
- rst high clears everything: all outputs 0, mode=RUN, blink=0, pending flags, timers, synchronizers.

Button inputs
- Each button passes through a 2-FF synchronizer, then a rising-edge detector.
- One press produces one event, 3 cycles after the input edge.

Mode FSM
- btn_mode event steps RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
- The `mode` output is registered.

Pulse channels
- Three channels (sec/min/hr). Each request makes the output go high for PLS_W cycles, then forces low for PLS_W cycles.
- The counter therefore sees one falling edge per request.
- A request while busy sets a one-deep pending flag; the pending request is issued immediately after the low phase.
- A request while busy with pending already set is dropped.

Clear channels
- Each clear request gives a PLS_W-cycle high strobe on that `*_clr` output.
- A clear request for a channel cancels that channel's pending pulse.
- If a pulse is in its high phase, it completes first.

Carry detection
- Registered falling edge of sec_carry means the seconds counter wrapped (59->0). Same for min_carry.

RUN mode
- tick_1hz requests sec_pls.
- Seconds carry edge requests min_pls; minutes carry edge requests hr_pls.
- btn_inc is ignored.
- btn_clr requests all three clears in the same cycle.

SET modes
- tick_1hz is ignored; time is halted.
- btn_inc requests one pulse on the selected field only.
- Carry edges are ignored: no propagation, so wrapping minutes does not bump hours.
- btn_clr clears the selected field only.

Mode change with activity in flight
- Any in-flight pulse completes.
- Pending requests are kept.
- Carries raised after entering SET are ignored.

Blink
- In SET modes, `blink` toggles every BLINK_DIV cycles.
- The blink counter restarts at each mode change, with blink=1 on entry.
- blink=0 in RUN.

Simultaneous events
- btn_mode and btn_inc in the same cycle: inc applies to the old mode, then the mode advances.
- tick and carry in the same cycle go to different channels and are both accepted.

Latency
- tick_1hz to sec_pls high: 1 cycle.
- Button edge to pulse high: 4 cycles.

Optional Feature:
WATCH_AUTO_REPEAT_EN
- Defined: in SET modes, holding btn_inc (synchronized level) for REPEAT_DLY cycles issues an extra increment request, then one more every REPEAT_PER cycles until release. Release resets the repeat timer.
- Undefined: one increment per press only; the REPEAT_* parameters are unused.

Test Plan:
1. Test parameters for all scenarios: PLS_W=4, BLINK_DIV=16, REPEAT_DLY=40, REPEAT_PER=10.
2. Reset, then apply tick_1hz -> sec_pls high 4 cycles starting the next cycle, then low; mode=0, blink=0.
3. RUN, force sec_carry 1->0 -> exactly one min_pls; min_carry 1->0 -> one hr_pls; two ticks 2 cycles apart -> two sec_pls pulses separated by >=4 low cycles; a third tick while busy+pending -> dropped.
4. Press btn_mode 2 times -> mode=2, blink=1 toggling every 16 cycles; ticks produce no sec_pls; btn_inc -> one min_pls; sec_carry falling edge -> no min_pls.
5. In SET_SEC, btn_clr -> sec_clr high 4 cycles, min_clr/hr_clr stay 0; in RUN, btn_clr -> all three clears high together.
6. Assert rst mid-pulse (sec_pls high, pending set) -> all outputs 0 immediately; after release, no residual pulse and mode=0.
7. With WATCH_AUTO_REPEAT_EN, hold btn_inc 75 cycles in SET_HR -> hr_pls count = 1 (press) + 1 (at 40) + 3 (at 50, 60, 70) = 5; without the macro -> 1.
